// File: rtl/score_keeper.sv
// Per-round score producer: accumulates hit points during play with a 2x combo
// bonus past a hit streak, then freezes and flags the final score on round finish.
module score_keeper #(
  parameter logic [2:0]  MODE_PLAY     = 3'b010,
  parameter logic [2:0]  MODE_FINISH   = 3'b101,
  parameter int unsigned STREAK_THRESH = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] mode,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] score,
  output logic [3:0] streak,
  output logic       combo,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam logic [3:0] THRESH = 4'(STREAK_THRESH);

  state_t     state_q, state_d;
  logic [3:0] score_q, score_d;
  logic [3:0] streak_q, streak_d;
  logic       done_q, done_d;
  logic [4:0] score_sum;

  // Bonus decision uses the pre-update streak; sum is widened so saturation can see overflow.
  assign score_sum = {1'b0, score_q} + ((streak_q >= THRESH) ? 5'd2 : 5'd1);

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    streak_d = streak_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mode == MODE_PLAY) begin
          state_d  = PLAY;
          score_d  = 4'd0;
          streak_d = 4'd0;
        end
      end
      PLAY: begin
        if (mode == MODE_PLAY) begin
          if (miss) begin
            streak_d = 4'd0;
          end else if (hit) begin
            score_d  = (score_sum > 5'd15) ? 4'd15 : score_sum[3:0];
            streak_d = (streak_q == 4'd15) ? 4'd15 : streak_q + 4'd1;
          end
        end else if (mode == MODE_FINISH) begin
          state_d = FINAL;
          done_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      FINAL: begin
        if (mode == MODE_PLAY) begin
          state_d  = PLAY;
          score_d  = 4'd0;
          streak_d = 4'd0;
        end else if (mode != MODE_FINISH) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      score_q  <= 4'd0;
      streak_q <= 4'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      streak_q <= streak_d;
      done_q   <= done_d;
    end
  end

  assign score  = score_q;
  assign streak = streak_q;
  assign combo  = (streak_q >= THRESH);
  assign done   = done_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed-vector bench for score_keeper with hand-computed expected values.
`timescale 1ns/1ps
module tb_score_keeper;

  localparam logic [2:0] M_PLAY   = 3'b010;
  localparam logic [2:0] M_FINISH = 3'b101;
  localparam logic [2:0] M_OTHER  = 3'b000;

  logic       clk;
  logic       n_rst;
  logic [2:0] mode;
  logic       hit;
  logic       miss;
  logic [3:0] score;
  logic [3:0] streak;
  logic       combo;
  logic       done;

  int vectors;
  int miscompares;

  score_keeper #(
    .MODE_PLAY     (M_PLAY),
    .MODE_FINISH   (M_FINISH),
    .STREAK_THRESH (4)
  ) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .mode   (mode),
    .hit    (hit),
    .miss   (miss),
    .score  (score),
    .streak (streak),
    .combo  (combo),
    .done   (done)
  );

  initial clk = 1'b0;
  always #42 clk = ~clk;

  // Inputs change on the falling edge; outputs are checked 1ns after the rising edge.
  task automatic applyStimulus(input logic [2:0] m, input logic h, input logic ms);
    @(negedge clk);
    mode = m;
    hit  = h;
    miss = ms;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  int seq6[6]   = '{1, 2, 3, 4, 6, 8};
  int combo6[6] = '{0, 0, 0, 1, 1, 1};
  int seq12[12] = '{1, 2, 3, 4, 6, 8, 10, 12, 14, 15, 15, 15};

  initial begin
    vectors     = 0;
    miscompares = 0;
    n_rst = 1'b0;
    mode  = M_OTHER;
    hit   = 1'b0;
    miss  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_score", score, 0);
    checkOutput("reset_streak", streak, 0);
    checkOutput("reset_combo", combo, 0);
    checkOutput("reset_done", done, 0);
    @(negedge clk);
    n_rst = 1'b1;

    $display("[TB] basic round: three hits then finish");
    applyStimulus(M_PLAY, 1'b0, 1'b0);
    checkOutput("entry_score", score, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(M_PLAY, 1'b1, 1'b0);
      checkOutput($sformatf("basic_hit%0d", i), score, i + 1);
    end
    applyStimulus(M_FINISH, 1'b0, 1'b0);
    checkOutput("fin_done", done, 1);
    checkOutput("fin_score", score, 3);
    checkOutput("fin_streak", streak, 3);
    checkOutput("fin_combo", combo, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(M_FINISH, 1'b0, 1'b0);
      checkOutput($sformatf("fin_hold_done%0d", i), done, 0);
      checkOutput($sformatf("fin_hold_score%0d", i), score, 3);
    end

    $display("[TB] combo: six consecutive hits");
    applyStimulus(M_PLAY, 1'b1, 1'b0);
    checkOutput("reentry_score", score, 0);
    checkOutput("reentry_streak", streak, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(M_PLAY, 1'b1, 1'b0);
      checkOutput($sformatf("combo_score%0d", i), score, seq6[i]);
      checkOutput($sformatf("combo_flag%0d", i), combo, combo6[i]);
    end

    $display("[TB] abort and finish from idle");
    applyStimulus(M_OTHER, 1'b0, 1'b0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_score", score, 8);
    applyStimulus(M_FINISH, 1'b0, 1'b0);
    checkOutput("idle_finish_done", done, 0);
    checkOutput("idle_finish_score", score, 8);

    $display("[TB] simultaneous hit and miss");
    applyStimulus(M_PLAY, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(M_PLAY, 1'b1, 1'b0);
    checkOutput("hm_pre_score", score, 4);
    applyStimulus(M_PLAY, 1'b1, 1'b1);
    checkOutput("hm_score", score, 4);
    checkOutput("hm_streak", streak, 0);
    applyStimulus(M_PLAY, 1'b1, 1'b0);
    checkOutput("hm_after_score", score, 5);
    checkOutput("hm_after_streak", streak, 1);
    checkOutput("hm_after_combo", combo, 0);

    $display("[TB] saturation over twelve hits");
    applyStimulus(M_FINISH, 1'b0, 1'b0);
    checkOutput("sat_pre_done", done, 1);
    applyStimulus(M_PLAY, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(M_PLAY, 1'b1, 1'b0);
      checkOutput($sformatf("sat_score%0d", i), score, seq12[i]);
    end
    checkOutput("sat_streak", streak, 12);

    $display("[TB] re-entry from final with a hit on the entry edge");
    applyStimulus(M_FINISH, 1'b0, 1'b0);
    applyStimulus(M_PLAY, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(M_PLAY, 1'b1, 1'b0);
    applyStimulus(M_PLAY, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(M_PLAY, 1'b1, 1'b0);
    checkOutput("s7_score", score, 7);
    applyStimulus(M_FINISH, 1'b1, 1'b0);
    checkOutput("s7_fin_score", score, 7);
    checkOutput("s7_fin_done", done, 1);
    applyStimulus(M_PLAY, 1'b1, 1'b0);
    checkOutput("s7_entry_score", score, 0);
    applyStimulus(M_PLAY, 1'b1, 1'b0);
    checkOutput("s7_next_score", score, 1);

    $display("[TB] asynchronous reset mid-round");
    for (int i = 0; i < 3; i++) applyStimulus(M_PLAY, 1'b1, 1'b0);
    applyStimulus(M_PLAY, 1'b0, 1'b1);
    applyStimulus(M_PLAY, 1'b1, 1'b0);
    checkOutput("rst_pre_score", score, 5);
    applyStimulus(M_PLAY, 1'b0, 1'b0);
    #10;
    n_rst = 1'b0;
    #1;
    checkOutput("rst_score", score, 0);
    checkOutput("rst_streak", streak, 0);
    checkOutput("rst_combo", combo, 0);
    checkOutput("rst_done", done, 0);
    #5;
    n_rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(M_FINISH, 1'b0, 1'b0);
      checkOutput($sformatf("rst_fin_done%0d", i), done, 0);
      checkOutput($sformatf("rst_fin_score%0d", i), score, 0);
    end
    applyStimulus(M_PLAY, 1'b1, 1'b0);
    checkOutput("rst_entry_score", score, 0);
    applyStimulus(M_PLAY, 1'b1, 1'b0);
    checkOutput("rst_entry_hit", score, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
